// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 codes, FSM states and counter sizing shared by dmem_access_unit
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte enables, store replication and load extension from funct3 and byte offset
import dmem_pkg::*;
module dmem_lane_align (
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{off, 3'b000} +: 8];
  assign h = off[1] ? rdata[31:16] : rdata[15:0];
  // funct3[1:0] is the access size; misaligned low bits fall away in the shifts
  assign be = funct3[1:0] == 2'd0 ? 4'b0001 << off :
              funct3[1:0] == 2'd1 ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
  assign wdata_rep = funct3[1:0] == 2'd0 ? {4{wdata[7:0]}} :
                     funct3[1:0] == 2'd1 ? {2{wdata[15:0]}} : wdata;
  assign rdata_ext = funct3 == F3_B  ? {{24{b[7]}}, b} :
                     funct3 == F3_BU ? {24'b0, b} :
                     funct3 == F3_H  ? {{16{h[15]}}, h} :
                     funct3 == F3_HU ? {16'b0, h} : rdata;
endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: load/store request to data-memory req/ack handshake with aligned, extended response.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses instead of truncating them.
import dmem_pkg::*;
module dmem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);
  localparam int CW = cnt_w(TIMEOUT_CYCLES);
  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic            err_q;
  logic [31:0]     rdata_q;
  logic            accept, bad_f3, fault, timeout;
  logic [3:0]      be;
  logic [31:0]     wrep, rext;
  assign accept  = req_valid && req_ready;
  assign bad_f3  = req_we ? req_funct3 > F3_W : req_funct3 inside {3'd3, 3'd6, 3'd7};
`ifdef DMEM_MISALIGN_TRAP_EN
  logic misal;
  assign misal = (req_funct3[1:0] == 2'd1 && req_addr[0]) || (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
  assign fault = bad_f3 || misal;
`else
  assign fault = bad_f3;
`endif
  assign timeout    = state == BUSY && !mem_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign req_ready  = state == IDLE && !rst;
  assign stall      = state != IDLE || accept;
  assign mem_req    = state == BUSY;
  assign resp_valid = state == RESP;
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'b0;
  // Request fields feed the aligner at acceptance; latched ones drive it while waiting for ack
  dmem_lane_align u_align (
    .funct3    (state == IDLE ? req_funct3 : f3_q),
    .off       (state == IDLE ? req_addr[1:0] : off_q),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .be        (be),
    .wdata_rep (wrep),
    .rdata_ext (rext)
  );
  always_comb begin
    state_n = state;
    if (state == IDLE && accept) state_n = fault ? RESP : BUSY;
    else if (state == BUSY && (mem_ack || timeout)) state_n = RESP;
    else if (state == RESP) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        f3_q      <= req_funct3;
        off_q     <= req_addr[1:0];
        err_q     <= fault;
        rdata_q   <= '0;
        cnt       <= '0;
        mem_we    <= req_we;
        mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
        mem_be    <= be;
        mem_wdata <= wrep;
      end
      if (state == BUSY) begin
        cnt <= (mem_ack || timeout) ? '0 : cnt + 1'b1;
        if (mem_ack) rdata_q <= mem_we ? 32'b0 : rext;
        else if (timeout) err_q <= 1'b1;
      end
    end
  end
endmodule
